iir_wb_fifo: RTL and testbench

//  Write-back stage directly downstream of the IIR filter. Captures each filtered sample and its

---
 rtl/iir_wb_fifo.sv | 139 +++++++++++++
 tb/tb_iir_wb_fifo.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_wb_fifo.sv
// iir_wb_fifo: write-back buffer behind the IIR filter.
// Each filtered sample and its address are queued in a small FIFO. The FIFO
// drains to result memory through a req/ack handshake. The filter's Finish
// is folded into a sticky done flag. That flag rises only once every accepted
// sample has been acknowledged by memory.
module iir_wb_fifo #(
    parameter int DW    = 16,
    parameter int AW    = 20,
    parameter int DEPTH = 8,
    parameter int PW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_wen,
    input  logic [DW-1:0] in_data,
    input  logic [AW-1:0] in_addr,
    input  logic          in_finish,
    output logic          full,
    output logic [PW:0]   level,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic          mem_ack,
    output logic [AW-1:0] wr_cnt,
    output logic          ovf,
    output logic          done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);

    logic [AW+DW-1:0] fifo_mem [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [1:0]       state_r;
    logic             fin_seen_r;

    logic             pop_s;
    logic             push_try_s;
    logic             push_s;
    logic             drop_s;
    logic [PW-1:0]    rd_ptr_n_s;
    logic [PW:0]      level_n_s;
    logic [1:0]       state_n_s;
    logic             load_head_s;
    logic [AW+DW-1:0] head_n_s;

    // Handshake qualification, occupancy bookkeeping and next FSM state.
    always_comb begin
        pop_s      = mem_req & mem_ack;
        push_try_s = in_wen & (state_r != S_DONE);
        // A full FIFO still takes a sample when the head leaves on the same edge.
        push_s     = push_try_s & (~full | pop_s);
        drop_s     = push_try_s & full & ~pop_s;
        rd_ptr_n_s = rd_ptr_r + PW'(pop_s);
        level_n_s  = level + (PW+1)'(push_s) - (PW+1)'(pop_s);

        case (state_r)
            S_IDLE: begin
                if (level_n_s != {(PW+1){1'b0}}) begin
                    state_n_s = S_SEND;
                end else if (fin_seen_r) begin
                    state_n_s = S_DONE;
                end else begin
                    state_n_s = S_IDLE;
                end
            end
            S_SEND: begin
                if (pop_s && (level_n_s == {(PW+1){1'b0}})) begin
                    state_n_s = S_IDLE;
                end else begin
                    state_n_s = S_SEND;
                end
            end
            S_DONE:  state_n_s = S_DONE;
            default: state_n_s = S_IDLE;
        endcase

        // Reload the head when a request starts or the current one is accepted.
        // The head is held while a request waits for ack.
        load_head_s = (state_n_s == S_SEND) & (~mem_req | pop_s);
        // When no stored entry survives the pop, the entry being pushed becomes the head.
        if (level == (PW+1)'(pop_s)) begin
            head_n_s = {in_addr, in_data};
        end else begin
            head_n_s = fifo_mem[rd_ptr_n_s];
        end
    end

    // FIFO storage. The array is not reset; the pointers alone define valid content.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_r] <= {in_addr, in_data};
        end
    end

    // Pointers, occupancy, status flags, FSM and registered memory-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            level      <= {(PW+1){1'b0}};
            full       <= 1'b0;
            state_r    <= S_IDLE;
            fin_seen_r <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= {AW{1'b0}};
            mem_data   <= {DW{1'b0}};
            wr_cnt     <= {AW{1'b0}};
            ovf        <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                wr_cnt <= wr_cnt + AW'(1'b1);
            end
            if (drop_s) begin
                ovf <= 1'b1;
            end
            if (in_finish) begin
                fin_seen_r <= 1'b1;
            end
            if (load_head_s) begin
                {mem_addr, mem_data} <= head_n_s;
            end
            rd_ptr_r <= rd_ptr_n_s;
            level    <= level_n_s;
            full     <= (level_n_s == DEPTH_L);
            state_r  <= state_n_s;
            mem_req  <= (state_n_s == S_SEND);
            done     <= (state_n_s == S_DONE);
        end
    end

endmodule

// File: tb/tb_iir_wb_fifo.sv
// Self-checking bench for iir_wb_fifo.
// The reference model is a queue of pending entries. It also tracks request,
// overflow, finish and done flags derived from the behavioural rules.
module tb_iir_wb_fifo;

    localparam int DW    = 16;
    localparam int AW    = 20;
    localparam int DEPTH = 8;
    localparam int PW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_wen;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_addr;
    logic          in_finish;
    logic          full;
    logic [PW:0]   level;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ack;
    logic [AW-1:0] wr_cnt;
    logic          ovf;
    logic          done;

    iir_wb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .PW(PW)) dut (
        .clk(clk), .rst(rst), .in_wen(in_wen), .in_data(in_data), .in_addr(in_addr),
        .in_finish(in_finish), .full(full), .level(level), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack), .wr_cnt(wr_cnt),
        .ovf(ovf), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    bit            m_req, m_ovf, m_done, m_fin;
    logic [AW-1:0] m_cnt;
    int            n_vec = 0;
    int            n_err = 0;
    logic [27:0]   exp_v, act_v;

    task automatic model_reset();
        q.delete();
        m_req  = 1'b0;
        m_ovf  = 1'b0;
        m_done = 1'b0;
        m_fin  = 1'b0;
        m_cnt  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_wen = 1'b0; in_finish = 1'b0; mem_ack = 1'b0;
        in_data = '0; in_addr = '0;
        @(posedge clk);
        #3;
        model_reset();
        rst = 1'b0;
    endtask

    // One clock edge with the given inputs; the model follows the behavioural rules.
    task automatic tick(input logic wen, input logic [DW-1:0] d, input logic [AW-1:0] a,
                        input logic fin, input logic ack);
        bit was_req;
        in_wen = wen; in_data = d; in_addr = a; in_finish = fin; mem_ack = ack;
        @(posedge clk);
        was_req = m_req;
        if (m_req && ack) begin
            void'(q.pop_front());
            m_cnt = m_cnt + 1'b1;
        end
        if (wen && !m_done) begin
            if (q.size() < DEPTH) q.push_back('{a: a, d: d});
            else m_ovf = 1'b1;
        end
        m_done = m_done || (!was_req && q.size() == 0 && m_fin);
        m_req  = (q.size() > 0) && !m_done;
        m_fin  = m_fin || fin;
        #1;
        exp_v = {m_req, q.size() == DEPTH, m_ovf, m_done, 4'(q.size()), m_cnt};
        act_v = {mem_req, full, ovf, done, level, wr_cnt};
    endtask

    task automatic test_reset();
        rst = 1'b1; in_wen = 1'b0; in_finish = 1'b0; mem_ack = 1'b0;
        in_data = '0; in_addr = '0;
        #12;
        n_vec++;
        if ({mem_req, full, ovf, done, level, wr_cnt, mem_addr, mem_data} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got req=%b full=%b ovf=%b done=%b lvl=%0d cnt=%0d a=%h d=%h, expected all zero",
                     mem_req, full, ovf, done, level, wr_cnt, mem_addr, mem_data);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        tick(1'b1, 16'h1234, 20'd5, 1'b0, 1'b1);
        n_vec++;
        if ({mem_req, mem_addr, mem_data} !== {1'b1, 20'd5, 16'h1234}) begin
            n_err++;
            $display("FAIL single_req: got req=%b a=%h d=%h, expected req=1 a=00005 d=1234", mem_req, mem_addr, mem_data);
        end
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        n_vec++;
        if ({mem_req, level, wr_cnt} !== {1'b0, 4'd0, 20'd1}) begin
            n_err++;
            $display("FAIL single_after: got req=%b lvl=%0d cnt=%0d, expected req=0 lvl=0 cnt=1", mem_req, level, wr_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 16'($urandom), 20'($urandom), 1'b0, 1'b0);
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL bp_fill[%0d]: got %h expected %h", i, act_v, exp_v);
            end
        end
        n_vec++;
        if ({level, full, ovf} !== {4'd8, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL bp_full: got lvl=%0d full=%b ovf=%b, expected lvl=8 full=1 ovf=1", level, full, ovf);
        end
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (m_req && ({mem_addr, mem_data} !== q[0])) begin
                n_err++;
                $display("FAIL bp_head[%0d]: got %h expected %h", i, {mem_addr, mem_data}, q[0]);
            end
            tick(1'b0, '0, '0, 1'b0, 1'b1);
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL bp_drain[%0d]: got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 16'($urandom), 20'($urandom), 1'b0, 1'b0);
        tick(1'b1, 16'hBEEF, 20'hABCDE, 1'b0, 1'b1);
        n_vec++;
        if ({ovf, level, full} !== {1'b0, 4'd8, 1'b1}) begin
            n_err++;
            $display("FAIL fs_simul: got ovf=%b lvl=%0d full=%b, expected ovf=0 lvl=8 full=1", ovf, level, full);
        end
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (m_req && ({mem_addr, mem_data} !== q[0])) begin
                n_err++;
                $display("FAIL fs_head[%0d]: got %h expected %h", i, {mem_addr, mem_data}, q[0]);
            end
            if (i == 7) begin
                n_vec++;
                if ({mem_req, mem_addr, mem_data} !== {1'b1, 20'hABCDE, 16'hBEEF}) begin
                    n_err++;
                    $display("FAIL fs_last: got req=%b a=%h d=%h, expected req=1 a=abcde d=beef", mem_req, mem_addr, mem_data);
                end
            end
            tick(1'b0, '0, '0, 1'b0, 1'b1);
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL fs_drain[%0d]: got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_finish();
        do_reset();
        tick(1'b1, 16'h0A01, 20'h00100, 1'b0, 1'b0);
        tick(1'b1, 16'h0A02, 20'h00101, 1'b0, 1'b0);
        tick(1'b1, 16'h0A03, 20'h00102, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (m_req && ({mem_addr, mem_data} !== q[0])) begin
                n_err++;
                $display("FAIL fin_head[%0d]: got %h expected %h", i, {mem_addr, mem_data}, q[0]);
            end
            tick(1'b0, '0, '0, 1'b0, 1'(i % 2));
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL fin_seq[%0d]: got %h expected %h", i, act_v, exp_v);
            end
        end
        n_vec++;
        if ({done, wr_cnt} !== {1'b1, 20'd3}) begin
            n_err++;
            $display("FAIL fin_done: got done=%b cnt=%0d, expected done=1 cnt=3", done, wr_cnt);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 16'($urandom), 20'($urandom), 1'b0, 1'b1);
        n_vec++;
        if ({done, level, ovf, mem_req} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL fin_ignore: got done=%b lvl=%0d ovf=%b req=%b, expected 1 0 0 0", done, level, ovf, mem_req);
        end
    endtask

    task automatic test_async_rst();
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 16'($urandom), 20'($urandom), 1'b0, 1'b0);
        n_vec++;
        if ({mem_req, level} !== {1'b1, 4'd4}) begin
            n_err++;
            $display("FAIL ar_pre: got req=%b lvl=%0d, expected req=1 lvl=4", mem_req, level);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL ar_req_drop: got req=%b expected 0", mem_req);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        n_vec++;
        if ({level, wr_cnt, done, mem_req} !== {4'd0, 20'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL ar_post: got lvl=%0d cnt=%0d done=%b req=%b, expected all zero", level, wr_cnt, done, mem_req);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 102; i++) begin
            n_vec++;
            if (m_req && ({mem_addr, mem_data} !== q[0])) begin
                n_err++;
                $display("FAIL st_head[%0d]: got %h expected %h", i, {mem_addr, mem_data}, q[0]);
            end
            tick(1'(i < 100), 16'($urandom), 20'($urandom), 1'b0, 1'b1);
            n_vec++;
            if ((act_v !== exp_v) || (level > 4'd1)) begin
                n_err++;
                $display("FAIL st_cycle[%0d]: got %h expected %h (level<=1)", i, act_v, exp_v);
            end
        end
        n_vec++;
        if ({wr_cnt, ovf} !== {20'd100, 1'b0}) begin
            n_err++;
            $display("FAIL st_total: got cnt=%0d ovf=%b, expected cnt=100 ovf=0", wr_cnt, ovf);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            n_vec++;
            if (m_req && ({mem_addr, mem_data} !== q[0])) begin
                n_err++;
                $display("FAIL rnd_head[%0d]: got %h expected %h", i, {mem_addr, mem_data}, q[0]);
            end
            tick(1'($urandom_range(0, 1)), 16'($urandom), 20'($urandom), 1'(i > 300 && $urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 2) != 0));
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL rnd_cycle[%0d]: got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_full_simul();
        test_finish();
        test_async_rst();
        test_stream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
